// File: rtl/spi_slave_reg_ctrl.sv
// spi_slave_reg_ctrl: turns an SPI byte stream (command byte + data/dummy bytes) into register bus strobes.
// Latency: bus_wr/bus_rd 1 clk after rec_valid; response_data loads read data 3 clk after the triggering rec_valid.
// Backpressure: none; every byte is consumed as it arrives and the register bus must take one strobe per cycle.
module spi_slave_reg_ctrl #(
  parameter int         AW     = 4,
  parameter logic [7:0] STATUS = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_n,
  input  logic [7:0]    rec_data,
  input  logic          rec_valid,
  output logic [7:0]    response_data,
  output logic          bus_wr,
  output logic          bus_rd,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_wdata,
  input  logic [7:0]    bus_rdata,
  output logic          frame_done,
  output logic [7:0]    byte_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WR      = 3'd2,
    RD      = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // chip-select synchroniser; sync_fill marks when cs_s holds a genuinely sampled value
  logic          cs_m;
  logic          cs_s;
  logic [1:0]    sync_fill;
  logic          sync_ok;

  logic [AW-1:0] addr;
  logic [AW-1:0] addr_nxt;
  logic [7:0]    cnt;
  logic [7:0]    cnt_nxt;
  logic [7:0]    cnt_inc;

  logic          wr_go;
  logic          rd_go;
  logic [AW-1:0] stb_addr;
  logic          fd_go;
  logic          in_frame;

  // a read strobe issued last cycle means bus_rdata is valid this cycle
  logic          rd_pend;

  assign sync_ok  = sync_fill[1];
  assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign in_frame = (state == CMD) || (state == WR) || (state == RD);

  // Two-flop synchroniser for the raw chip select; reset to "deselected".
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_m      <= 1'b1;
      cs_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      cs_m      <= cs_n;
      cs_s      <= cs_m;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // State, running address and per-frame byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_HI;
      addr  <= '0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode, address stepping and strobe requests.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    cnt_nxt   = cnt;
    wr_go     = 1'b0;
    rd_go     = 1'b0;
    stb_addr  = bus_addr;
    fd_go     = 1'b0;

    case (state)
      WAIT_HI: begin
        // only leave once a real deselect has been seen, so a frame cut by reset is dropped
        if (sync_ok && cs_s) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (!cs_s) begin
          state_nxt = CMD;
          cnt_nxt   = 8'd0;
        end
      end
      CMD: begin
        if (rec_valid) begin
          cnt_nxt  = cnt_inc;
          addr_nxt = rec_data[AW-1:0];
          if (rec_data[7]) begin
            state_nxt = RD;
            // first read is fetched straight away so its data is ready for the next byte
            rd_go     = !cs_s;
            stb_addr  = rec_data[AW-1:0];
          end else begin
            state_nxt = WR;
          end
        end
      end
      WR: begin
        if (rec_valid) begin
          cnt_nxt  = cnt_inc;
          wr_go    = 1'b1;
          stb_addr = addr;
          addr_nxt = addr + AW'(1);
        end
      end
      RD: begin
        if (rec_valid) begin
          // dummy byte: step and prefetch the following register
          cnt_nxt  = cnt_inc;
          addr_nxt = addr + AW'(1);
          rd_go    = !cs_s;
          stb_addr = addr + AW'(1);
        end
      end
      default: begin
        state_nxt = WAIT_HI;
      end
    endcase

    // deselect ends the frame; a byte arriving in the same cycle is still counted
    if (in_frame && cs_s) begin
      state_nxt = IDLE;
      fd_go     = (cnt_nxt != 8'd0);
    end
  end

  // Register bus strobes; address and data hold between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_wr    <= 1'b0;
      bus_rd    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 8'd0;
      rd_pend   <= 1'b0;
    end else begin
      bus_wr  <= wr_go;
      bus_rd  <= rd_go;
      rd_pend <= bus_rd;
      if (wr_go || rd_go) begin
        bus_addr <= stb_addr;
      end
      if (wr_go) begin
        bus_wdata <= rec_data;
      end
    end
  end

  // Frame completion pulse and the published byte count of the last frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      byte_cnt   <= 8'd0;
    end else begin
      frame_done <= fd_go;
      if (fd_go) begin
        byte_cnt <= cnt_nxt;
      end
    end
  end

  // Outgoing byte: read data after each fetch, STATUS outside read frames once no fetch is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      response_data <= STATUS;
    end else if (rd_pend) begin
      response_data <= bus_rdata;
    end else if (!bus_rd && (state != RD)) begin
      response_data <= STATUS;
    end
  end

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
module tb_spi_slave_reg_ctrl;

  localparam int         AW     = 4;
  localparam logic [7:0] STATUS = 8'hA5;
  localparam int         NREG   = 1 << AW;
  localparam int         AMASK  = NREG - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cs_n;
  logic [7:0]    rec_data;
  logic          rec_valid;
  logic [7:0]    response_data;
  logic          bus_wr;
  logic          bus_rd;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic [7:0]    bus_rdata;
  logic          frame_done;
  logic [7:0]    byte_cnt;

  always #5 clk = ~clk;

  spi_slave_reg_ctrl #(.AW(AW), .STATUS(STATUS)) dut (
    .clk           (clk),
    .rst           (rst),
    .cs_n          (cs_n),
    .rec_data      (rec_data),
    .rec_valid     (rec_valid),
    .response_data (response_data),
    .bus_wr        (bus_wr),
    .bus_rd        (bus_rd),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .frame_done    (frame_done),
    .byte_cnt      (byte_cnt)
  );

  typedef struct {
    bit is_wr;
    int addr;
    int data;
  } txn_t;

  int   checks = 0;
  int   errors = 0;

  // model state
  txn_t exp_q[$];
  int   fd_q[$];
  logic [7:0] regs [0:NREG-1];
  int   mdl_cnt   = 0;
  int   mdl_addr  = 0;
  int   mdl_wdata = 0;
  bit   mon_en    = 1'b0;
  bit   rd_phase  = 1'b0;
  int   quiet     = 0;
  int   cyc       = 0;
  int   rsp_due   = -1;
  logic [7:0] rsp_exp = 8'd0;
  int   rd_src    = -1;
  int   fd_seen   = 0;

  // observation logs for literal checks
  int   wr_addr_log[$];
  int   wr_data_log[$];
  int   rd_log[$];
  int   rsp_log[$];

  logic [7:0] fbytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Register-bank responder plus every-cycle comparison against the model.
  always @(negedge clk) begin
    txn_t e;
    cyc++;
    if (rd_src >= 0) bus_rdata = regs[rd_src];
    else             bus_rdata = 8'($urandom);
    rd_src = bus_rd ? int'(bus_addr) : -1;

    if (mon_en) begin
      if (cyc == rsp_due) begin
        check("rsp_rdata", 32'(response_data), 32'(rsp_exp));
        rsp_log.push_back(int'(response_data));
      end

      check("wr_rd_excl", 32'(bus_wr & bus_rd), 32'd0);
      if (bus_wr || bus_rd) begin
        if (exp_q.size() == 0) begin
          fail_event(bus_wr ? "stray_bus_wr" : "stray_bus_rd");
        end else begin
          e = exp_q.pop_front();
          check("stb_kind", 32'(bus_wr), 32'(e.is_wr));
          mdl_addr = e.addr;
          if (e.is_wr) begin
            mdl_wdata = e.data;
            regs[e.addr] = 8'(e.data);
            wr_addr_log.push_back(int'(bus_addr));
            wr_data_log.push_back(int'(bus_wdata));
          end else begin
            rd_log.push_back(int'(bus_addr));
            rsp_due = cyc + 2;
            rsp_exp = regs[e.addr];
          end
        end
      end
      check("bus_addr", 32'(bus_addr), 32'(mdl_addr));
      check("bus_wdata", 32'(bus_wdata), 32'(mdl_wdata));

      if (frame_done) begin
        fd_seen++;
        if (fd_q.size() == 0) fail_event("stray_frame_done");
        else                  mdl_cnt = fd_q.pop_front();
      end
      check("byte_cnt", 32'(byte_cnt), 32'(mdl_cnt));

      if (rd_phase || bus_rd) quiet = 0;
      else                    quiet++;
      if (quiet >= 7) check("rsp_status", 32'(response_data), 32'(STATUS));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rec_data  = b;
    rec_valid = 1'b1;
    @(negedge clk);
    rec_valid = 1'b0;
    rec_data  = 8'($urandom);
  endtask

  task automatic clr_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_log.delete();
    rsp_log.delete();
  endtask

  // One frame from fbytes: expected bus traffic derived from the command semantics.
  task automatic frame(input bit coinc, input bit fast);
    int a;
    bit rd;
    int n;
    bit last_c;
    n  = fbytes.size();
    a  = int'(fbytes[0]) & AMASK;
    rd = fbytes[0][7];
    fd_q.push_back(n > 255 ? 255 : n);
    rd_phase = rd;
    cs_n = 1'b0;
    tick(3 + $urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      last_c = coinc && (i == n - 1);
      if (last_c) begin
        cs_n = 1'b1;
        tick(2);
      end
      if (i == 0) begin
        if (rd && !last_c) exp_q.push_back('{is_wr: 1'b0, addr: a, data: 0});
      end else if (!rd) begin
        exp_q.push_back('{is_wr: 1'b1, addr: a, data: int'(fbytes[i])});
        a = (a + 1) & AMASK;
      end else begin
        a = (a + 1) & AMASK;
        if (!last_c) exp_q.push_back('{is_wr: 1'b0, addr: a, data: 0});
      end
      send(fbytes[i]);
      tick(fast ? 1 : $urandom_range(4, 9));
    end
    cs_n = 1'b1;
    rd_phase = 1'b0;
    tick(8);
    check("strobes_drained", 32'(exp_q.size()), 32'd0);
    check("frame_done_seen", 32'(fd_q.size()), 32'd0);
    exp_q.delete();
    fd_q.delete();
    tick($urandom_range(0, 3));
  endtask

  task automatic empty_frame();
    cs_n = 1'b0;
    tick(5 + $urandom_range(0, 3));
    cs_n = 1'b1;
    tick(8);
  endtask

  int fd_before;
  int m;

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
    rst       = 1'b1;
    cs_n      = 1'b1;
    rec_valid = 1'b0;
    rec_data  = 8'd0;
    bus_rdata = 8'd0;
    tick(3);
    check("rst_response", 32'(response_data), 32'hA5);
    check("rst_bus_wr", 32'(bus_wr), 32'd0);
    check("rst_bus_rd", 32'(bus_rd), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
    check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick(6);

    // write frame 03 11 22
    clr_logs();
    fbytes.delete(); fbytes.push_back(8'h03); fbytes.push_back(8'h11); fbytes.push_back(8'h22);
    frame(1'b0, 1'b0);
    check("wr_count", 32'(wr_addr_log.size()), 32'd2);
    check("wr0_addr", 32'(wr_addr_log[0]), 32'd3);
    check("wr0_data", 32'(wr_data_log[0]), 32'h11);
    check("wr1_addr", 32'(wr_addr_log[1]), 32'd4);
    check("wr1_data", 32'(wr_data_log[1]), 32'h22);
    check("wr_byte_cnt", 32'(byte_cnt), 32'd3);

    // read frame 85 + two dummies
    regs[5] = 8'h5A;
    regs[6] = 8'h6B;
    clr_logs();
    fbytes.delete(); fbytes.push_back(8'h85); fbytes.push_back(8'hFF); fbytes.push_back(8'h00);
    frame(1'b0, 1'b0);
    check("rd_count", 32'(rd_log.size()), 32'd3);
    check("rd0_addr", 32'(rd_log[0]), 32'd5);
    check("rd1_addr", 32'(rd_log[1]), 32'd6);
    check("rd2_addr", 32'(rd_log[2]), 32'd7);
    check("rsp0", 32'(rsp_log[0]), 32'h5A);
    check("rsp1", 32'(rsp_log[1]), 32'h6B);
    check("rd_byte_cnt", 32'(byte_cnt), 32'd3);

    // address wrap 15 -> 0
    clr_logs();
    fbytes.delete(); fbytes.push_back(8'h0F); fbytes.push_back(8'hC1); fbytes.push_back(8'hC2);
    frame(1'b0, 1'b0);
    check("wrap0_addr", 32'(wr_addr_log[0]), 32'd15);
    check("wrap1_addr", 32'(wr_addr_log[1]), 32'd0);
    check("wrap1_data", 32'(wr_data_log[1]), 32'hC2);

    // last write byte coincides with deselect
    clr_logs();
    fbytes.delete(); fbytes.push_back(8'h08); fbytes.push_back(8'h31); fbytes.push_back(8'h32); fbytes.push_back(8'h33);
    frame(1'b1, 1'b0);
    check("coinc_wr_count", 32'(wr_addr_log.size()), 32'd3);
    check("coinc_wr_last", 32'(wr_addr_log[2]), 32'd10);
    check("coinc_wr_cnt", 32'(byte_cnt), 32'd4);

    // last read dummy coincides with deselect: no trailing fetch
    clr_logs();
    fbytes.delete(); fbytes.push_back(8'h82); fbytes.push_back(8'h00); fbytes.push_back(8'h00);
    frame(1'b1, 1'b0);
    check("coinc_rd_count", 32'(rd_log.size()), 32'd2);
    check("coinc_rd_cnt", 32'(byte_cnt), 32'd3);

    // empty frame
    fd_before = fd_seen;
    empty_frame();
    check("empty_no_fd", 32'(fd_seen), 32'(fd_before));
    check("empty_cnt_held", 32'(byte_cnt), 32'd3);

    // reset in the middle of a write frame, chip select kept low
    fd_before = fd_seen;
    cs_n = 1'b0;
    tick(4);
    exp_q.push_back('{is_wr: 1'b1, addr: 2, data: 8'h77});
    send(8'h02);
    tick(5);
    send(8'h77);
    tick(5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    fd_q.delete();
    mdl_cnt   = 0;
    mdl_addr  = 0;
    mdl_wdata = 0;
    rsp_due   = -1;
    tick(2);
    rst = 1'b0;
    tick(5);
    send(8'h05);
    tick(5);
    send(8'h44);
    tick(5);
    cs_n = 1'b1;
    tick(8);
    check("abort_no_fd", 32'(fd_seen), 32'(fd_before));
    check("abort_cnt_zero", 32'(byte_cnt), 32'd0);
    clr_logs();
    fbytes.delete(); fbytes.push_back(8'h06); fbytes.push_back(8'h9C);
    frame(1'b0, 1'b0);
    check("post_abort_addr", 32'(wr_addr_log[0]), 32'd6);
    check("post_abort_cnt", 32'(byte_cnt), 32'd2);

    // byte count saturation
    fbytes.delete();
    fbytes.push_back(8'h00);
    for (int i = 0; i < 259; i++) fbytes.push_back(8'($urandom));
    frame(1'b0, 1'b1);
    check("sat_cnt", 32'(byte_cnt), 32'd255);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        empty_frame();
      end else begin
        fbytes.delete();
        fbytes.push_back(8'($urandom));
        m = $urandom_range(0, 6);
        for (int i = 0; i < m; i++) fbytes.push_back(8'($urandom));
        frame($urandom_range(0, 3) == 0, 1'b0);
      end
    end

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
